// File: rtl/acc_vec_25p_pkg.sv
// Shared constants for the 25-lane reduction/accumulation stage.
// Holds the lane count, default fixed-point format and the accumulator sizing rule.
package acc_vec_25p_pkg;

  localparam int LANES           = 25;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_POINT_WIDTH = 8;

  // Smallest accumulator that cannot overflow before saturation:
  // tree growth (+5), channel growth (clog2) and one bit for the bias add.
  function automatic int acc_width_min(input int width, input int ch_num);
    return width + 5 + $clog2(ch_num) + 1;
  endfunction

endpackage

// File: rtl/acc_vec_25p_add5.sv
// Five-input signed adder, purely combinational.
// Each operand is sign-extended from IN_W to OUT_W before summing.
module add5_sx
  import acc_vec_25p_pkg::*;
#(
  parameter int IN_W  = DEF_WIDTH,
  parameter int OUT_W = IN_W + 3
) (
  input  logic [5*IN_W-1:0] din,
  output logic [OUT_W-1:0]  sum
);

  always_comb begin
    // NOTE: blocking '=' is right in combinational logic, because the running
    // sum must see its own update each iteration; registers use '<=' only.
    sum = '0;
    for (int i = 0; i < 5; i++) begin
      sum = sum + {{(OUT_W-IN_W){din[i*IN_W+IN_W-1]}}, din[i*IN_W +: IN_W]};
    end
  end

endmodule

// File: rtl/acc_vec_25p.sv
// Sums a 25-product vector per cycle through a registered adder tree, accumulates
// CH_NUM vectors, adds a bias and emits one saturated WIDTH-bit result per group.
module acc_vec_25p
  import acc_vec_25p_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int POINT_WIDTH = DEF_POINT_WIDTH,
  parameter int CH_NUM      = 6,
  parameter int ACC_WIDTH   = WIDTH + 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [WIDTH*LANES-1:0] inP_25P,
  input  logic [WIDTH-1:0]       bias,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       outSum,
  output logic                   sat
);

  localparam int P1_W   = WIDTH + 3;
  localparam int TREE_W = WIDTH + 5;
  localparam int CNT_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CH_NUM - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  generate
    if (CH_NUM < 1 || POINT_WIDTH >= WIDTH ||
        ACC_WIDTH < acc_width_min(WIDTH, CH_NUM)) begin : g_bad_params
      $error("acc_vec_25p: illegal CH_NUM / POINT_WIDTH / ACC_WIDTH combination");
    end
  endgenerate

  logic [4:0][P1_W-1:0]   p1_d, p1_q;
  logic                   v1_d, v1_q;
  logic [TREE_W-1:0]      tree_d, tree_q;
  logic                   v2_d, v2_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q, fin_d, fin_q;
  logic signed [ACC_WIDTH-1:0] acc_next, tree_sx, bias_sx;
  logic                   done_d, done_q, last_beat;
  logic                   out_valid_d, out_valid_q;
  logic [WIDTH-1:0]       out_sum_d, out_sum_q;
  logic                   sat_d, sat_q;

  // S1: five lane groups of five, S2: one adder over the five partials.
  generate
    for (genvar g = 0; g < 5; g++) begin : g_s1
      add5_sx #(.IN_W(WIDTH), .OUT_W(P1_W)) u_add (
        .din(inP_25P[g*5*WIDTH +: 5*WIDTH]),
        .sum(p1_d[g])
      );
    end
  endgenerate

  add5_sx #(.IN_W(P1_W), .OUT_W(TREE_W)) u_add_s2 (
    .din(p1_q),
    .sum(tree_d)
  );

  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch is inferred.
    v1_d        = in_valid & ~clear;
    v2_d        = v1_q & ~clear;
    tree_sx     = {{(ACC_WIDTH-TREE_W){tree_q[TREE_W-1]}}, tree_q};
    bias_sx     = {{(ACC_WIDTH-WIDTH){bias[WIDTH-1]}}, bias};
    acc_next    = ((cnt_q == '0) ? '0 : acc_q) + tree_sx;
    last_beat   = v2_q && (cnt_q == CNT_LAST);
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    fin_d       = fin_q;
    done_d      = 1'b0;
    out_valid_d = done_q;
    out_sum_d   = out_sum_q;
    sat_d       = sat_q;

    if (v2_q) begin
      acc_d = acc_next;
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    end
    if (last_beat) begin
      fin_d  = acc_next + bias_sx;
      done_d = 1'b1;
    end
    // Abort drops the in-flight beats; S4 still takes whatever done_q holds.
    if (clear) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end

    if (done_q) begin
      if (fin_q > SAT_MAX) begin
        out_sum_d = {1'b0, {(WIDTH-1){1'b1}}};
        sat_d     = 1'b1;
      end else if (fin_q < SAT_MIN) begin
        out_sum_d = {1'b1, {(WIDTH-1){1'b0}}};
        sat_d     = 1'b1;
      end else begin
        out_sum_d = fin_q[WIDTH-1:0];
        sat_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q        <= '0;
      v1_q        <= 1'b0;
      tree_q      <= '0;
      v2_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      fin_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      p1_q        <= p1_d;
      v1_q        <= v1_d;
      tree_q      <= tree_d;
      v2_q        <= v2_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      fin_q       <= fin_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign outSum    = out_sum_q;
  assign sat       = sat_q;

endmodule
